// File: rtl/result_readout_ctrl.sv
// result_readout_ctrl
//  Reader side of the results SRAM. Fetches num_words result words starting at
//  base_addr and streams each word out one partial sum (column) per beat on a
//  valid/ready interface. One read per word, no prefetch: every word costs two
//  bubble cycles (READ, WAIT) followed by MATRIX_SIZE accepted beats.
//  Optional build macro: RESULT_RELU_EN -- when defined, negative partial sums
//  are clamped to zero at the output mux (SRAM contents are never modified).
module result_readout_ctrl #(
  parameter int ADDRESSSIZE     = 10,
  parameter int MATRIX_SIZE     = 8,
  parameter int PARTIAL_SUM_BW  = 20,
  parameter int WORDSIZE_Result = PARTIAL_SUM_BW * MATRIX_SIZE,
  parameter int COL_W           = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ADDRESSSIZE-1:0]     base_addr,
  input  logic [ADDRESSSIZE:0]       num_words,
  output logic                       sram_rd_en,
  output logic [ADDRESSSIZE-1:0]     sram_address,
  input  logic [WORDSIZE_Result-1:0] sram_data_out,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [PARTIAL_SUM_BW-1:0]  m_data,
  output logic [COL_W-1:0]           m_col,
  output logic                       m_last,
  output logic                       busy,
  output logic                       done
);

  localparam logic [COL_W-1:0]       LAST_COL  = COL_W'(MATRIX_SIZE - 1);
  localparam logic [ADDRESSSIZE:0]   ONE_WORD  = (ADDRESSSIZE + 1)'(1);
  localparam logic [ADDRESSSIZE:0]   ZERO_WORD = (ADDRESSSIZE + 1)'(0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_SEND = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t                     state_r;
  state_t                     state_nxt_s;
  logic [ADDRESSSIZE-1:0]     addr_r;
  logic [ADDRESSSIZE:0]       words_left_r;
  logic [COL_W-1:0]           col_r;
  logic [WORDSIZE_Result-1:0] word_r;
  logic [PARTIAL_SUM_BW-1:0]  beat_s;
  logic [PARTIAL_SUM_BW-1:0]  out_data_s;
  logic                       last_col_s;
  logic                       more_words_s;

  // Clamp a two's complement partial sum to zero when negative.
  function automatic logic [PARTIAL_SUM_BW-1:0] relu_f(input logic [PARTIAL_SUM_BW-1:0] v);
    logic [PARTIAL_SUM_BW-1:0] r;
    if (v[PARTIAL_SUM_BW-1]) begin
      r = {PARTIAL_SUM_BW{1'b0}};
    end else begin
      r = v;
    end
    return r;
  endfunction

  assign last_col_s   = (col_r == LAST_COL);
  assign more_words_s = (words_left_r > ONE_WORD);
  assign sram_address = addr_r;

  // State register; reset aborts any transfer in progress without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: one READ/WAIT/SEND round per result word.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (num_words == ZERO_WORD) begin
            state_nxt_s = S_FIN;
          end else begin
            state_nxt_s = S_READ;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_READ:  state_nxt_s = S_WAIT;
      S_WAIT:  state_nxt_s = S_SEND;
      S_SEND: begin
        if (m_ready && last_col_s) begin
          if (more_words_s) begin
            state_nxt_s = S_READ;
          end else begin
            state_nxt_s = S_FIN;
          end
        end else begin
          state_nxt_s = S_SEND;
        end
      end
      S_FIN:   state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Datapath: latch the job, capture the SRAM word, step column/word/address counters.
  // The address register only changes on entry to READ, so the SRAM address holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r       <= {ADDRESSSIZE{1'b0}};
      words_left_r <= ZERO_WORD;
      col_r        <= {COL_W{1'b0}};
      word_r       <= {WORDSIZE_Result{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start && (num_words != ZERO_WORD)) begin
            addr_r       <= base_addr;
            words_left_r <= num_words;
            col_r        <= {COL_W{1'b0}};
          end
        end
        S_WAIT: begin
          word_r <= sram_data_out;
        end
        S_SEND: begin
          if (m_ready) begin
            if (last_col_s) begin
              col_r        <= {COL_W{1'b0}};
              words_left_r <= words_left_r - ONE_WORD;
              if (more_words_s) begin
                addr_r <= addr_r + ADDRESSSIZE'(1);
              end
            end else begin
              col_r <= col_r + COL_W'(1);
            end
          end
        end
        default: begin
          addr_r <= addr_r;
        end
      endcase
    end
  end

  // Output column mux, with optional negative clamping on the streamed value only.
  always_comb begin
    beat_s = word_r[int'(col_r) * PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
`ifdef RESULT_RELU_EN
    out_data_s = relu_f(beat_s);
`else
    out_data_s = beat_s;
`endif
  end

  // Moore output decode; every output is zero in IDLE and stream fields only show in SEND.
  always_comb begin
    sram_rd_en = 1'b0;
    m_valid    = 1'b0;
    m_data     = {PARTIAL_SUM_BW{1'b0}};
    m_col      = {COL_W{1'b0}};
    m_last     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_r)
      S_IDLE: busy = 1'b0;
      S_READ: begin
        sram_rd_en = 1'b1;
        busy       = 1'b1;
      end
      S_WAIT: busy = 1'b1;
      S_SEND: begin
        m_valid = 1'b1;
        m_data  = out_data_s;
        m_col   = col_r;
        m_last  = last_col_s && (words_left_r == ONE_WORD);
        busy    = 1'b1;
      end
      S_FIN: begin
        done = 1'b1;
        busy = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_result_readout_ctrl.sv
// Testbench for result_readout_ctrl: table of readout jobs run against a
// behavioural SRAM, plus hand-written reset sequences.
module tb_result_readout_ctrl;

  localparam int MS = 8;
  localparam int PW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [9:0]    base_addr;
  logic [10:0]   num_words;
  logic          sram_rd_en;
  logic [9:0]    sram_address;
  logic [159:0]  sram_data_out;
  logic          m_valid;
  logic          m_ready;
  logic [19:0]   m_data;
  logic [2:0]    m_col;
  logic          m_last;
  logic          busy;
  logic          done;

  logic [159:0]  mem [0:1023];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [9:0]  base;
    logic [10:0] num;
    logic [3:0]  rdy;        // m_ready pattern, indexed by SEND cycle mod 4
    int          exp_done;   // observation index of done after start, -1 = not checked
    logic        poke;       // pulse a second start while busy
    logic        chk_first;
    logic [19:0] exp_first;  // hand value of the very first beat
  } vec_t;

  vec_t tbl [6];

  result_readout_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .num_words     (num_words),
    .sram_rd_en    (sram_rd_en),
    .sram_address  (sram_address),
    .sram_data_out (sram_data_out),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_col         (m_col),
    .m_last        (m_last),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Results SRAM model: one-cycle registered read.
  always @(posedge clk) begin
    if (sram_rd_en) sram_data_out <= mem[sram_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [19:0] exp_val(input logic [9:0] a, input int k);
    logic [159:0] w;
    logic [19:0]  v;
    w = mem[a];
    v = w[k*PW +: PW];
`ifdef RESULT_RELU_EN
    if (v[19]) v = 20'h00000;
`endif
    return v;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, " ctl"}, {27'd0, sram_rd_en, m_valid, m_last, busy, done}, 32'd0);
    check({tag, " addr"}, {22'd0, sram_address}, 32'd0);
    check({tag, " data"}, {9'd0, m_col, m_data}, 32'd0);
  endtask

  task automatic run_xfer(input vec_t v, input string tag);
    int n, rd_cnt, beats, lasts, busy_cnt, first_rd, first_val, send_cyc, done_n, widx, k;
    logic [9:0] ea;
    logic rdy, exp_last;
    n = 0; rd_cnt = 0; beats = 0; lasts = 0; busy_cnt = 0; send_cyc = 0;
    first_rd = -1; first_val = -1; done_n = -1;
    start = 1'b1; base_addr = v.base; num_words = v.num; m_ready = 1'b1;
    step();
    start = 1'b0;
    while (done_n < 0 && n < 400) begin
      if (busy) busy_cnt++;
      if (sram_rd_en) begin
        if (first_rd < 0) first_rd = n;
        ea = v.base + 10'(rd_cnt);
        check({tag, " rd_addr"}, {22'd0, sram_address}, {22'd0, ea});
        rd_cnt++;
      end
      if (m_valid) begin
        if (first_val < 0) first_val = n;
        widx = beats / MS;
        k = beats % MS;
        ea = v.base + 10'(widx);
        exp_last = (k == MS - 1) && (widx == int'(v.num) - 1);
        check({tag, " beat"}, {8'd0, m_last, m_col, m_data}, {8'd0, exp_last, 3'(k), exp_val(ea, k)});
        if (v.chk_first && beats == 0) check({tag, " first_data"}, {12'd0, m_data}, {12'd0, v.exp_first});
        rdy = v.rdy[send_cyc % 4];
        send_cyc++;
        if (rdy) begin
          beats++;
          if (m_last) lasts++;
        end
        m_ready = rdy;
      end else begin
        m_ready = 1'b1;
      end
      if (done) done_n = n;
      if (v.poke && n == 3) begin
        start = 1'b1; base_addr = 10'h155; num_words = 11'd5;
      end else begin
        start = 1'b0;
      end
      if (done_n < 0) begin
        step();
        n++;
      end
    end
    start = 1'b0;
    m_ready = 1'b1;
    check({tag, " done_seen"}, (done_n >= 0) ? 32'd1 : 32'd0, 32'd1);
    check({tag, " rd_count"}, rd_cnt, 32'(v.num));
    check({tag, " beats"}, beats, 32'(v.num) * MS);
    check({tag, " last_count"}, lasts, (v.num != 11'd0) ? 32'd1 : 32'd0);
    check({tag, " busy_cycles"}, busy_cnt, done_n + 1);
    if (v.exp_done >= 0) check({tag, " done_time"}, done_n, v.exp_done);
    if (v.num != 11'd0) begin
      check({tag, " first_rd"}, first_rd, 32'd0);
      check({tag, " first_valid"}, first_val, 32'd2);
    end
    step();
    check({tag, " after_done"}, {29'd0, done, busy, m_valid}, 32'd0);
  endtask

  initial begin
    int dones;
    logic [2:0] kk;
    logic [9:0] aa;
    for (int a = 0; a < 1024; a++) begin
      aa = 10'(a);
      for (int k = 0; k < MS; k++) begin
        kk = 3'(k);
        mem[a][k*PW +: PW] = {kk[0], aa, 1'b0, kk, 5'h0A};
      end
    end
    for (int k = 0; k < MS; k++) mem[10'h010][k*PW +: PW] = 20'(k + 1);
    mem[10'h020][0 +: PW]  = 20'hFFFFF;
    mem[10'h020][PW +: PW] = 20'h00005;

    //         base     num     rdy      done poke chk   first
    tbl[0] = '{10'h010, 11'd1, 4'b1111, 10, 1'b0, 1'b1, 20'h00001};
    tbl[1] = '{10'h3FE, 11'd3, 4'b1111, 30, 1'b1, 1'b0, 20'h00000};
    tbl[2] = '{10'h010, 11'd1, 4'b1001, 18, 1'b0, 1'b1, 20'h00001};
    tbl[3] = '{10'h000, 11'd0, 4'b1111, 0,  1'b0, 1'b0, 20'h00000};
`ifdef RESULT_RELU_EN
    tbl[4] = '{10'h020, 11'd1, 4'b1111, 10, 1'b0, 1'b1, 20'h00000};
`else
    tbl[4] = '{10'h020, 11'd1, 4'b1111, 10, 1'b0, 1'b1, 20'hFFFFF};
`endif
    tbl[5] = '{10'h1F0, 11'd2, 4'b0110, -1, 1'b0, 1'b0, 20'h00000};

    rst = 1'b1; start = 1'b0; base_addr = 10'h000; num_words = 11'd0; m_ready = 1'b1;
    sram_data_out = 160'd0;
    step(); step(); step();
    check_idle_outputs("reset");
    // start coinciding with reset must be ignored
    start = 1'b1; num_words = 11'd1; base_addr = 10'h010;
    step();
    start = 1'b0;
    check_idle_outputs("rst_wins");
    rst = 1'b0;
    step();
    check_idle_outputs("idle_after_rst");

    for (int i = 0; i < 6; i++) begin
      run_xfer(tbl[i], $sformatf("v%0d", i));
      step();
    end

    // Reset during beat 3 of the second word of a four-word job.
    start = 1'b1; base_addr = 10'h040; num_words = 11'd4; m_ready = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 15; i++) step();
    check("midrst position", {11'd0, m_valid, m_col, m_data}, {11'd0, 1'b1, 3'd3, exp_val(10'h041, 3)});
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_idle_outputs("midrst");
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy || m_valid || sram_rd_en) dones++;
      step();
    end
    check("midrst quiet", dones, 32'd0);
    run_xfer(tbl[0], "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
